// File: rtl/alu_sequencer.sv
// alu_sequencer: request/response front end for the 16-bit ALU datapath.
// Sequences one operation at a time through operand load, execute and
// output phases on the ALU's shared bus and enables, then returns the
// captured result on a response handshake.
//
// Optional feature macro: ALU_SEQ_CHAIN_EN
//   Adds req_chain; when set, operand A is the last completed result.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_op, req_a, req_b       opcode (0..6 legal, 7 illegal) and operands
//   req_chain                  (ALU_SEQ_CHAIN_EN only) use last result as A
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_err          result and illegal-opcode flag
//   busy                       high whenever not idle
//   alu_bus_in, alu_op         ALU Bus_in and OpControl
//   alu_in1_en, alu_in2_en     ALU operand register enables
//   alu_out_reg_en, alu_out_en ALU result register / output drive enables
//   alu_bus_out                ALU Bus_out
module alu_sequencer #(
  localparam int unsigned DATA_W = 16,
  localparam int unsigned OP_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic              req_chain,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic [DATA_W-1:0] alu_bus_in,
  output logic              alu_in1_en,
  output logic              alu_in2_en,
  output logic              alu_out_reg_en,
  output logic              alu_out_en,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_bus_out
);

  localparam logic [OP_W-1:0] OP_NOT     = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ILLEGAL = OP_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_DRIVE,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
`ifdef ALU_SEQ_CHAIN_EN
  logic                chain_q, chain_d;
  logic [DATA_W-1:0]   last_q, last_d;
`endif

  // Registered outputs, decoded from the next state so they line up with it
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   bus_in_q, bus_in_d;
  logic                in1_en_q, in1_en_d;
  logic                in2_en_q, in2_en_d;
  logic                out_reg_en_q, out_reg_en_d;
  logic                out_en_q, out_en_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   operand_a;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
      chain_q      <= 1'b0;
      last_q       <= '0;
`endif
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      bus_in_q     <= '0;
      in1_en_q     <= 1'b0;
      in2_en_q     <= 1'b0;
      out_reg_en_q <= 1'b0;
      out_en_q     <= 1'b0;
      alu_op_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
`ifdef ALU_SEQ_CHAIN_EN
      chain_q      <= chain_d;
      last_q       <= last_d;
`endif
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
      bus_in_q     <= bus_in_d;
      in1_en_q     <= in1_en_d;
      in2_en_q     <= in2_en_d;
      out_reg_en_q <= out_reg_en_d;
      out_en_q     <= out_en_d;
      alu_op_q     <= alu_op_d;
    end
  end

  // Next-state, request latch and output decode
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
`ifdef ALU_SEQ_CHAIN_EN
    chain_d    = chain_q;
    last_d     = last_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          a_d  = req_a;
          b_d  = req_b;
`ifdef ALU_SEQ_CHAIN_EN
          chain_d = req_chain;
`endif
          // Illegal ops answer immediately and never touch the ALU
          if (req_op == OP_ILLEGAL) begin
            state_d    = S_RESP;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end else begin
            state_d = S_LOAD_A;
          end
        end
      end
      S_LOAD_A: state_d = (op_q == OP_NOT) ? S_EXEC : S_LOAD_B;
      S_LOAD_B: state_d = S_EXEC;
      S_EXEC:   state_d = S_DRIVE;
      S_DRIVE: begin
        state_d    = S_RESP;
        rsp_data_d = alu_bus_out;
        rsp_err_d  = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
        last_d     = alu_bus_out;
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    operand_a = a_d;
`ifdef ALU_SEQ_CHAIN_EN
    // Previous op has fully retired before any accept, so last_q is current
    if (chain_d) begin
      operand_a = last_q;
    end
`endif

    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    rsp_valid_d  = (state_d == S_RESP);
    in1_en_d     = (state_d == S_LOAD_A);
    in2_en_d     = (state_d == S_LOAD_B);
    out_reg_en_d = (state_d == S_EXEC);
    out_en_d     = (state_d == S_DRIVE);
    alu_op_d     = (state_d inside {S_LOAD_A, S_LOAD_B, S_EXEC, S_DRIVE}) ? op_d : '0;
    bus_in_d     = '0;
    if (state_d == S_LOAD_A) begin
      bus_in_d = operand_a;
    end else if (state_d == S_LOAD_B) begin
      bus_in_d = b_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign busy           = busy_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign alu_bus_in     = bus_in_q;
  assign alu_in1_en     = in1_en_q;
  assign alu_in2_en     = in2_en_q;
  assign alu_out_reg_en = out_reg_en_q;
  assign alu_out_en     = out_en_q;
  assign alu_op         = alu_op_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Controller that drives the 16-bit ALU datapath from a simple request/response handshake. It accepts one operation at a time (opcode plus two operands) and sequences the ALU's shared bus and enables through operand load, execute, and output phases. It captures the ALU result and returns it on a response handshake. It sits between an instruction-issue front end and the ALU, and is the only driver of the ALU's `Bus_in`, enables and `OpControl`.

## Interface
- `DATA_W`, 16, operand/result width; matches ALU bus width.
- `OP_W`, 3, opcode width; matches ALU `OpControl`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_op`  in  OP_W  ALU opcode: 0 ADD, 1 SUB, 2 NOT, 3 AND, 4 OR, 5 XOR, 6 XNOR, 7 illegal.
- `req_a`  in  DATA_W  operand A.
- `req_b`  in  DATA_W  operand B; ignored for NOT.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_data`  out  DATA_W  result.
- `rsp_err`  out  1  illegal opcode flag, valid with `rsp_valid`.
- `busy`  out  1  high in any state other than IDLE.
- `alu_bus_in`  out  DATA_W  to ALU `Bus_in`.
- `alu_in1_en`, `alu_in2_en`, `alu_out_reg_en`, `alu_out_en`  out  1 each  to the matching ALU enables.
- `alu_op`  out  OP_W  to ALU `OpControl`.
- `alu_bus_out`  in  DATA_W  from ALU `Bus_out`.

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, DRIVE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch op/A/B.
  - Next state is LOAD_A if op≤6, or RESP with `rsp_err`=1 and `rsp_data`=0 if op=7.
- LOAD_A: `alu_bus_in`=A, `alu_in1_en`=1. Next state is LOAD_B, or EXEC if op=NOT.
- LOAD_B: `alu_bus_in`=B, `alu_in2_en`=1. Next state is EXEC.
- EXEC: `alu_out_reg_en`=1. Next state is DRIVE.
- DRIVE: `alu_out_en`=1. `rsp_data` <= `alu_bus_out` at end of cycle, `rsp_err` <= 0. Next state is RESP.
- RESP: `rsp_valid`=1, with data and err held stable. On `rsp_ready`, go to IDLE.
- Output rules:
  - `alu_op` = latched op from LOAD_A through DRIVE; otherwise 0.
  - `alu_bus_in` = 0 outside LOAD_A/LOAD_B.
  - At most one ALU enable is high per cycle.
- An illegal opcode produces no ALU activity at all: no enable asserted, `alu_op` stays 0.
- `req_valid` outside IDLE is ignored (not latched).

## Timing
- Reset values:
  - State IDLE.
  - `req_ready`=1 from the first cycle after reset.
  - All other outputs 0, including `rsp_data`, `rsp_err`, `busy`, all `alu_*` outputs.
- Latency from the accept edge to `rsp_valid` high:
  - 5 cycles for binary ops.
  - 4 cycles for NOT.
  - 1 cycle for op 7.
- Maximum throughput is one op per 6 cycles, because `req_ready` is low from the accept edge until the cycle after RESP completes.
- The RESP→IDLE edge and the next accept cannot coincide.
- Backpressure: RESP is held indefinitely while `rsp_ready`=0; `rsp_data` is unchanged throughout.
- Reset asserted in any state:
  - Next edge returns to IDLE with all outputs at reset values.
  - The in-flight request and any pending response are discarded.
- The ALU shares `reset`; the sequencer does not drive it.

## Configuration
- `ALU_SEQ_CHAIN_EN` defined:
  - Adds input `req_chain` (1 bit, latched with the request).
  - When set, LOAD_A drives the last completed result register instead of `req_a`, for accumulator-style chaining.
  - The last result is 0 after reset.
  - Erroring ops do not update the last result.
- `ALU_SEQ_CHAIN_EN` undefined: no `req_chain` port; operand A is always `req_a`.

## Test plan
- ADD, A=0x0055, B=0x0055, `rsp_ready`=1 → `rsp_data`=0x00AA, `rsp_err`=0, `rsp_valid` exactly 5 cycles after accept; enables pulse in order in1, in2, out_reg, out.
- SUB, A=0x0010, B=0x0020 → 0xFFF0; XNOR, A=0x00FF, B=0x0F0F → 0xF00F.
- NOT, A=0x00FF → 0xFF00, latency 4, `alu_in2_en` never asserted.
- op=7 → `rsp_valid` 1 cycle after accept, `rsp_err`=1, `rsp_data`=0, no `alu_*` activity.
- ADD with `rsp_ready` low for 3 cycles in RESP → `rsp_data` stable, `req_ready`=0 throughout, and a second `req_valid` during that window is not accepted.
- `reset` pulsed during EXEC → next cycle IDLE, all outputs 0, `req_ready`=1. With `ALU_SEQ_CHAIN_EN`: ADD 3+4 then chained ADD B=5 → 0x000C.
